pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register for the P6-style 5-stage MIPS core; generalises the fixed E->M stage register.
- Carries instr, pc and an opaque payload with a valid/ready handshake and a one-entry skid buffer, so a downstream stall does not combinationally gate the upstream stage.
- Exposes qualified forwarding (address, value, pending) for both held entries.
- The forwarding fields are pre-decoded upstream; this block does no opcode decode.

Parameters:
PAYLOAD_W, 168, width of opaque payload (cmpresult, rdata1, rdata2, extout, hi, lo).
DW, 32, instr/pc/forward-value width.
AW, 5, register address width.
PC_RST, 0, reset/flush value of out_pc.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_flush  in  1  kill all held entries and the input this cycle
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_instr  in  DW  instruction word
in_pc  in  DW  instruction pc
in_payload  in  PAYLOAD_W  opaque stage data
in_fw_we  in  1  entry writes a GPR
in_fw_a  in  AW  destination GPR
in_fw_v  in  DW  result value (meaningful only when in_fw_rdy)
in_fw_rdy  in  1  value already computed (0 for loads, etc.)
out_valid  out  1  main entry valid
out_ready  in  1  downstream takes main entry
out_instr  out  DW  main entry instr
out_pc  out  DW  main entry pc
out_payload  out  PAYLOAD_W  main entry payload
fw_a  out  AW  main entry forward address, 0 if none
fw_v  out  DW  main entry forward value
fw_pend  out  1  main entry writes fw_a but the value is not ready
fws_a  out  AW  skid entry forward address, 0 if none
fws_v  out  DW  skid entry forward value
fws_pend  out  1  skid entry writes fws_a but the value is not ready

Behaviour:
- Storage: main entry and skid entry, each holding {instr, pc, payload, fw_we, fw_a, fw_v, fw_rdy}.
- States: EMPTY (no entry), ONE (main only), FULL (main + skid).
- Handshakes:
  - accept = in_valid & in_ready.
  - take = out_valid & out_ready.
  - in_ready = (state != FULL); decoded from registered state only, with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Transitions:
  - EMPTY: accept -> ONE, main <= in.
  - ONE:
    - accept & take -> ONE, main <= in.
    - accept & !take -> FULL, skid <= in.
    - !accept & take -> EMPTY.
    - otherwise hold.
  - FULL: take -> ONE, main <= skid; otherwise hold.
- Timing: latency is 1 cycle from accept to out_valid; throughput is 1 entry/cycle with out_ready held high. Entry order is preserved.
- Priority: reset > in_flush > normal.
  - in_flush forces state EMPTY.
  - in_flush clears all stored fields (instr=0, i.e. nop; pc=PC_RST).
  - The input presented in the flush cycle is dropped even if in_valid=1.
- Reset clears the same stored fields: state EMPTY, out_instr=0, out_pc=PC_RST, out_payload=0, in_ready=1, fw_a=fws_a=0, fw_v=fws_v=0, fw_pend=fws_pend=0.
- out_instr/out_pc/out_payload hold their last value when out_valid=0; consumers must qualify with out_valid.
- Forwarding, main entry:
  - fw_a = (out_valid & fw_we & fw_a!=0) ? fw_a : 0.
  - fw_v = (fw_a output != 0 & fw_rdy) ? stored value : 0.
  - fw_pend = (fw_a output != 0) & !fw_rdy.
- Forwarding, skid entry: identical rules, qualified by state==FULL.
- The skid entry is younger, so consumers give fws_* priority over fw_*; a hazard unit stalls on a pending match. This block does no address matching.
- All forward outputs are purely combinational from registered state.

Optional Feature:
- Macro PIPE_SKID_PERF_EN.
- When defined, adds two output ports:
  - out_stall_cnt (32): counts cycles with out_valid & !out_ready.
  - out_bubble_cnt (32): counts cycles with !out_valid.
- Both counters saturate at 32'hFFFFFFFF, clear on reset only (not on flush), and keep counting during flush cycles.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (the existing constants include) gains:
  - the state encodings ST_EMPTY/ST_ONE/ST_FULL;
  - the entry bundle width, derived as DW*2 + PAYLOAD_W + 1 + AW + DW + 1.
- One sub-module, pipe_entry_reg: a bundle-wide register with load enable and synchronous clear. It is instantiated twice (main, skid).
- Forwarding qualification stays inline.

Test Plan:
- Reset then idle: after reset, in_ready=1, out_valid=0, out_pc=PC_RST, fw_a=0, fw_pend=0.
- Streaming with out_ready=1: in_pc 0x3000, 0x3004, 0x3008 on consecutive cycles -> out_pc shows the same sequence one cycle later; in_ready stays 1.
- Backpressure:
  - out_ready=0 while two entries are sent (pc 0x3000, 0x3004) -> cycle 2 has in_ready=0, state FULL, out_pc=0x3000, fws_a is the second entry's destination.
  - Releasing out_ready -> 0x3000, then 0x3004 taken in order; in_ready returns to 1 the cycle after the first take.
- Forward qualification:
  - Entry with fw_we=1, fw_a=8, fw_v=0x1234, fw_rdy=1 -> fw_a=8, fw_v=0x1234.
  - Same entry with fw_rdy=0 -> fw_pend=1, fw_v=0.
  - Same entry with fw_a=0 -> fw_a=0, fw_pend=0.
- Flush:
  - in_flush asserted while FULL with in_valid=1 -> next cycle out_valid=0, out_instr=0, all fw outputs 0, input dropped.
  - A simultaneous reset and flush behaves as reset.
- Perf (PIPE_SKID_PERF_EN): 5 cycles of out_valid & !out_ready plus 3 empty cycles -> out_stall_cnt=5, out_bubble_cnt counts all empty cycles including post-reset idle; a flush does not clear either counter.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared constants for the pipeline skid register: state encodings,
// default widths and the packed entry bundle width helper.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int DEF_PAYLOAD_W = 168;
  localparam int DEF_DW        = 32;
  localparam int DEF_AW        = 5;

  // Entry bundle: {instr, pc, payload, fw_we, fw_a, fw_v, fw_rdy}
  function automatic int entry_width(input int dw, input int payload_w, input int aw);
    return dw * 2 + payload_w + 1 + aw + dw + 1;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_entry.sv
// pipe_entry_reg: bundle-wide register with load enable and synchronous
// clear. Clear and reset both restore CLR_VAL; clear wins over load.
module pipe_entry_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] ent_q;
  logic [W-1:0] ent_d;

  // Next value: clear beats load, otherwise hold.
  always_comb begin
    ent_d = ent_q;
    if (clr) begin
      ent_d = CLR_VAL;
    end else if (ld) begin
      ent_d = d;
    end
  end

  // Storage flop with synchronous reset to the clear value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= CLR_VAL;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign q = ent_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with valid/ready handshake, a
// one-entry skid buffer and qualified forwarding for both held entries.
// in_ready depends only on registered state, so a downstream stall never
// reaches upstream combinationally.
// Optional macro PIPE_SKID_PERF_EN adds saturating stall/bubble counters.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int            PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int            DW        = DEF_DW,
  parameter int            AW        = DEF_AW,
  parameter logic [DW-1:0] PC_RST    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_instr,
  input  logic [DW-1:0]        in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_fw_we,
  input  logic [AW-1:0]        in_fw_a,
  input  logic [DW-1:0]        in_fw_v,
  input  logic                 in_fw_rdy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_instr,
  output logic [DW-1:0]        out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [AW-1:0]        fw_a,
  output logic [DW-1:0]        fw_v,
  output logic                 fw_pend,
  output logic [AW-1:0]        fws_a,
  output logic [DW-1:0]        fws_v,
  output logic                 fws_pend
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]          out_stall_cnt,
  output logic [31:0]          out_bubble_cnt
`endif
);

  localparam int EW     = entry_width(DW, PAYLOAD_W, AW);
  localparam int V_LSB  = 1;
  localparam int A_LSB  = DW + 1;
  localparam int WE_BIT = DW + AW + 1;
  localparam int PL_LSB = DW + AW + 2;
  localparam int PC_LSB = PL_LSB + PAYLOAD_W;
  localparam int IN_LSB = PC_LSB + DW;

  // A cleared entry is a nop at PC_RST with everything else zero.
  localparam logic [EW-1:0] CLR_BUNDLE = {{DW{1'b0}}, PC_RST, {(EW - 2 * DW){1'b0}}};

  state_t        state_q;
  state_t        state_d;
  logic          accept;
  logic          take;
  logic          main_ld;
  logic          skid_ld;
  logic [EW-1:0] in_bundle;
  logic [EW-1:0] main_d;
  logic [EW-1:0] main_q;
  logic [EW-1:0] skid_q;

  logic          m_we;
  logic          m_rdy;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_v;
  logic          s_we;
  logic          s_rdy;
  logic [AW-1:0] s_a;
  logic [DW-1:0] s_v;

  assign in_bundle = {in_instr, in_pc, in_payload, in_fw_we, in_fw_a, in_fw_v, in_fw_rdy};

  // A flushed cycle drops its input even if in_valid is high.
  assign accept = in_valid & in_ready & ~in_flush;
  assign take   = out_valid & out_ready;

  // The main entry refills from the skid when draining FULL, else from input.
  assign main_d = (state_q == ST_FULL) ? skid_q : in_bundle;

  pipe_entry_reg #(
    .W       (EW),
    .CLR_VAL (CLR_BUNDLE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .clr   (in_flush),
    .ld    (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_entry_reg #(
    .W       (EW),
    .CLR_VAL (CLR_BUNDLE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (in_flush),
    .ld    (skid_ld),
    .d     (in_bundle),
    .q     (skid_q)
  );

  assign m_rdy = main_q[0];
  assign m_v   = main_q[V_LSB +: DW];
  assign m_a   = main_q[A_LSB +: AW];
  assign m_we  = main_q[WE_BIT];
  assign s_rdy = skid_q[0];
  assign s_v   = skid_q[V_LSB +: DW];
  assign s_a   = skid_q[A_LSB +: AW];
  assign s_we  = skid_q[WE_BIT];

  assign out_payload = main_q[PL_LSB +: PAYLOAD_W];
  assign out_pc      = main_q[PC_LSB +: DW];
  assign out_instr   = main_q[IN_LSB +: DW];

  // State register; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and entry load enables; flush empties the stage.
  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_ld = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && take) begin
          main_ld = 1'b1;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_ld = 1'b1;
        end else if (take) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (take) begin
          state_d = ST_ONE;
          main_ld = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (in_flush) begin
      state_d = ST_EMPTY;
    end
  end

  // Handshake outputs and qualified forwarding, all from registered state.
  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    fw_a      = '0;
    fw_v      = '0;
    fws_a     = '0;
    fws_v     = '0;
    if (out_valid && m_we && (m_a != '0)) begin
      fw_a = m_a;
    end
    if ((fw_a != '0) && m_rdy) begin
      fw_v = m_v;
    end
    fw_pend = (fw_a != '0) && !m_rdy;
    if ((state_q == ST_FULL) && s_we && (s_a != '0)) begin
      fws_a = s_a;
    end
    if ((fws_a != '0) && s_rdy) begin
      fws_v = s_v;
    end
    fws_pend = (fws_a != '0) && !s_rdy;
  end

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;

  // Saturating stall and bubble counters; flush does not touch them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!out_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset only.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_stall_cnt  = stall_cnt_q;
  assign out_bubble_cnt = bubble_cnt_q;
`endif

endmodule
